// File: rtl/shift_unit_seq.sv
// shift_unit_seq: iterative SLL / SRL / SRA unit, one bit position per clock.
//
// An accepted start loads the operand, the amount and the operation. The unit
// then shifts once per cycle until the amount reaches zero, and pulses done
// for one cycle. The pipeline stalls while busy is high.
//
// Parameters
//   WIDTH  operand / result width
//   SHW    shift-amount width, 2**SHW must be >= WIDTH
//
// Ports
//   clk    clock, rising edge
//   rst    asynchronous reset, active high
//   start  request, sampled only in IDLE or DONE
//   op     00 SLL, 01 SRL, 11 SRA, 10 reserved (runs as SRL)
//   a      operand, captured on an accepted start
//   shamt  shift amount, captured on an accepted start
//   abort  pipeline flush, wins over start in every state
//   busy   high while shifting
//   done   one-cycle pulse, y is valid in this cycle
//   y      result, driven straight from the working register
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; work holds the last result
// SHIFT | one bit position per edge until cnt runs out
// DONE  | result valid for one cycle; a new start is accepted here
module shift_unit_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [SHW-1:0]   shamt,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] y
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRA = 2'b11;

    state_t           state;
    logic [WIDTH-1:0] work;
    logic [SHW-1:0]   cnt;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] shifted;

    // Single-position shift of the working register. Op code 10 falls into
    // the SRL arm on purpose.
    always_comb begin
        shifted = work;
        case (op_q)
            OP_SLL:  shifted = {work[WIDTH-2:0], 1'b0};
            OP_SRA:  shifted = {work[WIDTH-1], work[WIDTH-1:1]};
            default: shifted = {1'b0, work[WIDTH-1:1]};
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            work  <= '0;
            cnt   <= '0;
            op_q  <= '0;
        end else if (abort) begin
            // work keeps its partial value; any start in this cycle is dropped
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        work  <= a;
                        cnt   <= shamt;
                        op_q  <= op;
                        state <= (shamt != '0) ? SHIFT : DONE;
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    work <= shifted;
                    cnt  <= cnt - SHW'(1);
                    if (cnt == SHW'(1)) begin
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == SHIFT);
    assign done = (state == DONE);
    assign y    = work;

endmodule

// File: tb/tb_shift_unit_seq.sv
// Directed bench for shift_unit_seq: expected results go into a queue when an
// operation is issued and are popped when done pulses.
module tb_shift_unit_seq;

    localparam int WIDTH = 32;
    localparam int SHW   = 5;

    logic             clk;
    logic             rst;
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [SHW-1:0]   shamt;
    logic             abort;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] y;

    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] exp_q[$];

    shift_unit_seq #(.WIDTH(WIDTH), .SHW(SHW)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .shamt (shamt),
        .abort (abort),
        .busy  (busy),
        .done  (done),
        .y     (y)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                         input logic [WIDTH-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Drives start for one edge (edge k) and returns #1 after that edge.
    task automatic start_op(input logic [1:0] o, input logic [WIDTH-1:0] av,
                            input logic [SHW-1:0] sh, input logic [WIDTH-1:0] expy,
                            input bit push);
        if (push) exp_q.push_back(expy);
        op    = o;
        a     = av;
        shamt = sh;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Waits for done, counting edges and busy cycles since the call.
    task automatic wait_done(input string tag, input int exp_edges);
        int n;
        int busy_cycles;
        logic [WIDTH-1:0] expy;
        n = 0;
        busy_cycles = 0;
        while (!done && n < 100) begin
            if (busy) busy_cycles++;
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_done"}, WIDTH'(done), WIDTH'(1));
        check({tag, "_latency"}, WIDTH'(n), WIDTH'(exp_edges));
        check({tag, "_busy_cycles"}, WIDTH'(busy_cycles), WIDTH'(exp_edges));
        check({tag, "_busy_with_done"}, WIDTH'(busy), WIDTH'(0));
        expy = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        check({tag, "_y"}, y, expy);
    endtask

    task automatic watch_no_done(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            check(tag, WIDTH'(done), WIDTH'(0));
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        op    = 2'b00;
        a     = '0;
        shamt = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_busy", WIDTH'(busy), WIDTH'(0));
        check("reset_done", WIDTH'(done), WIDTH'(0));
        check("reset_y", y, WIDTH'(0));

        // SRA of a negative operand
        start_op(2'b11, 32'h8000_0010, 5'd4, 32'hF800_0001, 1'b1);
        wait_done("sra4", 4);
        @(posedge clk);
        #1;
        check("sra4_pulse_width", WIDTH'(done), WIDTH'(0));
        check("sra4_y_hold", y, 32'hF800_0001);

        // Zero amount: no busy, done right after the start edge
        start_op(2'b00, 32'h1234_5678, 5'd0, 32'h1234_5678, 1'b1);
        wait_done("sll0", 0);

        // Long SRL; a start pulse during SHIFT must be ignored
        start_op(2'b01, 32'hFFFF_FFFF, 5'd31, 32'h0000_0001, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        op    = 2'b00;
        a     = '0;
        shamt = 5'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("srl31", 25);
        watch_no_done("srl31_no_extra_done", 3);

        // SRA of a positive operand, and the reserved op code runs as SRL
        start_op(2'b11, 32'h7000_0000, 5'd3, 32'h0E00_0000, 1'b1);
        wait_done("sra_pos", 3);
        start_op(2'b10, 32'h8000_0000, 5'd1, 32'h4000_0000, 1'b1);
        wait_done("op10_srl", 1);

        // Abort sampled at edge k+3: two shifts happened, no done follows
        start_op(2'b00, 32'h0000_0001, 5'd8, '0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        abort = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        start = 1'b0;
        check("abort_busy", WIDTH'(busy), WIDTH'(0));
        check("abort_done", WIDTH'(done), WIDTH'(0));
        check("abort_y_partial", y, 32'h0000_0004);
        watch_no_done("abort_no_done", 12);
        start_op(2'b01, 32'h0000_0100, 5'd8, 32'h0000_0001, 1'b1);
        wait_done("after_abort", 8);

        // Back-to-back: second start accepted in the DONE cycle of the first
        start_op(2'b00, 32'h0000_0001, 5'd2, 32'h0000_0004, 1'b1);
        wait_done("b2b_first", 2);
        start_op(2'b11, 32'h8000_0000, 5'd1, 32'hC000_0000, 1'b1);
        check("b2b_no_idle_busy", WIDTH'(busy), WIDTH'(1));
        wait_done("b2b_second", 1);

        // Asynchronous reset in the middle of a cycle while shifting
        start_op(2'b00, 32'h0000_00FF, 5'd10, '0, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy", WIDTH'(busy), WIDTH'(0));
        check("arst_done", WIDTH'(done), WIDTH'(0));
        check("arst_y", y, WIDTH'(0));
        @(posedge clk);
        #3;
        rst = 1'b0;
        watch_no_done("arst_no_done", 15);
        start_op(2'b01, 32'hA5A5_0000, 5'd16, 32'h0000_A5A5, 1'b1);
        wait_done("after_arst", 16);

        check("queue_empty", WIDTH'(exp_q.size()), WIDTH'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
